// File: rtl/multi_alarm_pkg.sv
// Shared types and constants for the multi-alarm unit: edit FSM encoding,
// BCD digit type, digit wrap limits and the digit increment helper.
package multi_alarm_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SET_M0 = 3'd1;
    localparam logic [2:0] ST_SET_M1 = 3'd2;
    localparam logic [2:0] ST_SET_H0 = 3'd3;
    localparam logic [2:0] ST_SET_H1 = 3'd4;
    localparam logic [2:0] ST_ARM    = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_SET_M0 = ST_SET_M0,
        S_SET_M1 = ST_SET_M1,
        S_SET_H0 = ST_SET_H0,
        S_SET_H1 = ST_SET_H1,
        S_ARM    = ST_ARM
    } edit_state_e;

    localparam bcd_t M0_MAX     = 4'd9;
    localparam bcd_t M1_MAX     = 4'd5;
    localparam bcd_t H0_MAX     = 4'd9;
    localparam bcd_t H1_MAX     = 4'd2;
    localparam bcd_t H0_MAX_H20 = 4'd3;

    typedef struct packed {
        bcd_t h1;
        bcd_t h0;
        bcd_t m1;
        bcd_t m0;
    } alarm_time_t;

    function automatic bcd_t bcd_inc(input bcd_t d, input bcd_t lim);
        if (d >= lim) begin
            return 4'd0;
        end else begin
            return d + 4'd1;
        end
    endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: stored time, arm flag, time comparator, ring window and
// (when SNOOZE_EN is defined) the snooze countdown.
module alarm_channel
    import multi_alarm_pkg::*;
#(
    parameter int SNOOZE_MIN = 5,
    parameter int RING_MIN   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        min_tick_i,
    input  alarm_time_t cur_time_i,
    input  logic        wr_en_i,
    input  alarm_time_t wr_time_i,
    input  logic        tgl_en_i,
    input  logic        editing_i,
    input  logic        clr_ring_i,
    input  logic        ack_i,
    input  logic        snooze_i,
    output alarm_time_t time_o,
    output logic        en_o,
    output logic        ring_o
);

    alarm_time_t time_q, time_d;
    logic        en_q, en_d;
    logic        ring_q, ring_d;
    logic [3:0]  rcnt_q, rcnt_d;
    logic        match_s;

`ifdef SNOOZE_EN
    logic [3:0]  snz_q, snz_d;
`else
    logic        unused_snooze_s;
    assign unused_snooze_s = snooze_i;
`endif

    assign match_s = en_q && !editing_i && (time_q == cur_time_i);

    // Next-state: ack beats snooze beats edit-entry clear beats a minute match
    always_comb begin
        time_d = time_q;
        en_d   = en_q;
        ring_d = ring_q;
        rcnt_d = rcnt_q;
`ifdef SNOOZE_EN
        snz_d  = snz_q;
`endif
        if (wr_en_i) begin
            time_d = wr_time_i;
        end else begin
            time_d = time_q;
        end
        if (tgl_en_i) begin
            en_d = !en_q;
        end else begin
            en_d = en_q;
        end
        if (ack_i) begin
            ring_d = 1'b0;
            rcnt_d = 4'd0;
`ifdef SNOOZE_EN
            snz_d  = 4'd0;
`endif
        end
`ifdef SNOOZE_EN
        else if (snooze_i && ring_q) begin
            ring_d = 1'b0;
            rcnt_d = 4'd0;
            snz_d  = 4'(SNOOZE_MIN);
        end
`endif
        else if (clr_ring_i) begin
            ring_d = 1'b0;
            rcnt_d = 4'd0;
        end else if (min_tick_i) begin
            if (match_s) begin
                ring_d = 1'b1;
                rcnt_d = 4'(RING_MIN);
            end else if (ring_q && (rcnt_q <= 4'd1)) begin
                ring_d = 1'b0;
                rcnt_d = 4'd0;
            end else if (ring_q) begin
                rcnt_d = rcnt_q - 4'd1;
            end else begin
                rcnt_d = rcnt_q;
            end
`ifdef SNOOZE_EN
            // Snooze expiry restarts a full ring window
            if (snz_q != 4'd0) begin
                snz_d = snz_q - 4'd1;
                if (snz_q == 4'd1) begin
                    ring_d = 1'b1;
                    rcnt_d = 4'(RING_MIN);
                end else begin
                    ring_d = ring_d;
                end
            end else begin
                snz_d = snz_q;
            end
`endif
        end else begin
            ring_d = ring_q;
        end
    end

    // Channel state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            time_q <= alarm_time_t'(16'h0000);
            en_q   <= 1'b0;
            ring_q <= 1'b0;
            rcnt_q <= 4'd0;
`ifdef SNOOZE_EN
            snz_q  <= 4'd0;
`endif
        end else begin
            time_q <= time_d;
            en_q   <= en_d;
            ring_q <= ring_d;
            rcnt_q <= rcnt_d;
`ifdef SNOOZE_EN
            snz_q  <= snz_d;
`endif
        end
    end

    assign time_o = time_q;
    assign en_o   = en_q;
    assign ring_o = ring_q;

endmodule

// File: rtl/multi_alarm_unit.sv
// Multi-channel alarm clock: digit-by-digit edit FSM plus NUM_ALARMS channels.
// Optional snooze support is compiled in with the SNOOZE_EN macro.
module multi_alarm_unit
    import multi_alarm_pkg::*;
#(
    parameter int NUM_ALARMS = 4,
    parameter int SNOOZE_MIN = 5,
    parameter int RING_MIN   = 3,
    localparam int SEL_W     = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  min_tick,
    input  logic [3:0]            cur_h1,
    input  logic [3:0]            cur_h0,
    input  logic [3:0]            cur_m1,
    input  logic [3:0]            cur_m0,
    input  logic                  mode_btn,
    input  logic                  set_btn,
    input  logic                  ack_btn,
    input  logic                  snooze_btn,
    input  logic [SEL_W-1:0]      sel,
    output logic [3:0]            disp_h1,
    output logic [3:0]            disp_h0,
    output logic [3:0]            disp_m1,
    output logic [3:0]            disp_m0,
    output logic [2:0]            edit_state,
    output logic [NUM_ALARMS-1:0] alarm_en,
    output logic [NUM_ALARMS-1:0] ringing,
    output logic                  buzzer
);

    // Channel array padded to a power of two so any pointer value is in range
    localparam int NCH = 1 << SEL_W;

    edit_state_e       state_q, state_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic              buzzer_q;
    logic              wr_en_s, tgl_s, clr_s;
    alarm_time_t       wr_time_s, edit_time_s, disp_time_s, cur_time_s;
    logic [SEL_W-1:0]  disp_idx_s;
    alarm_time_t       chan_time_s [NCH];
    logic [NCH-1:0]    chan_en_s;
    logic [NCH-1:0]    chan_ring_s;

    assign cur_time_s  = '{h1: cur_h1, h0: cur_h0, m1: cur_m1, m0: cur_m0};
    assign edit_time_s = chan_time_s[ptr_q];
    assign disp_idx_s  = (state_q == S_IDLE) ? sel : ptr_q;
    assign disp_time_s = chan_time_s[disp_idx_s];

    // Edit FSM next-state and digit update; mode_btn wins over set_btn
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        wr_en_s   = 1'b0;
        tgl_s     = 1'b0;
        clr_s     = 1'b0;
        wr_time_s = edit_time_s;
        if (mode_btn) begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_SET_M0;
                    ptr_d   = sel;
                    clr_s   = 1'b1;
                end
                S_SET_M0: state_d = S_SET_M1;
                S_SET_M1: state_d = S_SET_H0;
                S_SET_H0: state_d = S_SET_H1;
                S_SET_H1: state_d = S_ARM;
                S_ARM:    state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end else if (set_btn) begin
            case (state_q)
                S_SET_M0: begin
                    wr_en_s      = 1'b1;
                    wr_time_s.m0 = bcd_inc(edit_time_s.m0, M0_MAX);
                end
                S_SET_M1: begin
                    wr_en_s      = 1'b1;
                    wr_time_s.m1 = bcd_inc(edit_time_s.m1, M1_MAX);
                end
                S_SET_H0: begin
                    wr_en_s      = 1'b1;
                    wr_time_s.h0 = bcd_inc(edit_time_s.h0,
                                           (edit_time_s.h1 == H1_MAX) ? H0_MAX_H20 : H0_MAX);
                end
                S_SET_H1: begin
                    wr_en_s      = 1'b1;
                    wr_time_s.h1 = bcd_inc(edit_time_s.h1, H1_MAX);
                    // Entering the 20s must never leave an hour above 23
                    if ((wr_time_s.h1 == H1_MAX) && (edit_time_s.h0 > H0_MAX_H20)) begin
                        wr_time_s.h0 = H0_MAX_H20;
                    end else begin
                        wr_time_s.h0 = edit_time_s.h0;
                    end
                end
                S_ARM:   tgl_s = 1'b1;
                default: wr_en_s = 1'b0;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // FSM, edit pointer and buzzer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= {SEL_W{1'b0}};
            buzzer_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            buzzer_q <= |chan_ring_s;
        end
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        if (gi < NUM_ALARMS) begin : g_real
            alarm_channel #(
                .SNOOZE_MIN (SNOOZE_MIN),
                .RING_MIN   (RING_MIN)
            ) u_chan (
                .clk        (clk),
                .rst        (rst),
                .min_tick_i (min_tick),
                .cur_time_i (cur_time_s),
                .wr_en_i    (wr_en_s && (ptr_q == SEL_W'(gi))),
                .wr_time_i  (wr_time_s),
                .tgl_en_i   (tgl_s && (ptr_q == SEL_W'(gi))),
                .editing_i  ((state_q != S_IDLE) && (ptr_q == SEL_W'(gi))),
                .clr_ring_i (clr_s && (sel == SEL_W'(gi))),
                .ack_i      (ack_btn),
                .snooze_i   (snooze_btn),
                .time_o     (chan_time_s[gi]),
                .en_o       (chan_en_s[gi]),
                .ring_o     (chan_ring_s[gi])
            );
        end else begin : g_pad
            assign chan_time_s[gi] = alarm_time_t'(16'h0000);
            assign chan_en_s[gi]   = 1'b0;
            assign chan_ring_s[gi] = 1'b0;
        end
    end

    assign disp_h1    = disp_time_s.h1;
    assign disp_h0    = disp_time_s.h0;
    assign disp_m1    = disp_time_s.m1;
    assign disp_m0    = disp_time_s.m0;
    assign edit_state = state_q;
    assign alarm_en   = chan_en_s[NUM_ALARMS-1:0];
    assign ringing    = chan_ring_s[NUM_ALARMS-1:0];
    assign buzzer     = buzzer_q;

endmodule

// File: tb/tb_multi_alarm_unit.sv
// Self-checking bench for multi_alarm_unit: directed scenarios followed by
// random button/tick traffic, all checked against a behavioural model.
module tb_multi_alarm_unit;

    localparam int N   = 4;
    localparam int SNZ = 5;
    localparam int RNG = 3;
`ifdef SNOOZE_EN
    localparam bit SNZ_ON = 1'b1;
`else
    localparam bit SNZ_ON = 1'b0;
`endif

    logic       clk = 1'b0, rst = 1'b1, min_tick = 1'b0;
    logic       mode_btn = 1'b0, set_btn = 1'b0, ack_btn = 1'b0, snooze_btn = 1'b0;
    logic [3:0] cur_h1 = 4'd0, cur_h0 = 4'd0, cur_m1 = 4'd0, cur_m0 = 4'd0;
    logic [1:0] sel = 2'd0;
    logic [3:0] disp_h1, disp_h0, disp_m1, disp_m0;
    logic [2:0] edit_state;
    logic [N-1:0] alarm_en, ringing;
    logic       buzzer;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: times held as digit arrays [m0,m1,h0,h1] per channel
    int m_st, m_ptr, m_buz;
    int m_tm [N][4];
    bit m_en [N];
    bit m_ring [N];
    int m_rc [N];
    int m_snz [N];

    multi_alarm_unit #(.NUM_ALARMS(N), .SNOOZE_MIN(SNZ), .RING_MIN(RNG)) dut (
        .clk(clk), .rst(rst), .min_tick(min_tick),
        .cur_h1(cur_h1), .cur_h0(cur_h0), .cur_m1(cur_m1), .cur_m0(cur_m0),
        .mode_btn(mode_btn), .set_btn(set_btn), .ack_btn(ack_btn), .snooze_btn(snooze_btn),
        .sel(sel),
        .disp_h1(disp_h1), .disp_h0(disp_h0), .disp_m1(disp_m1), .disp_m0(disp_m0),
        .edit_state(edit_state), .alarm_en(alarm_en), .ringing(ringing), .buzzer(buzzer)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_ptr = 0; m_buz = 0;
        for (int i = 0; i < N; i++) begin
            for (int d = 0; d < 4; d++) m_tm[i][d] = 0;
            m_en[i] = 1'b0; m_ring[i] = 1'b0; m_rc[i] = 0; m_snz[i] = 0;
        end
    endtask

    task automatic model_update();
        int  c [4];
        int  p;
        bit  hit;
        c[0] = int'(cur_m0); c[1] = int'(cur_m1); c[2] = int'(cur_h0); c[3] = int'(cur_h1);
        m_buz = 0;
        for (int i = 0; i < N; i++) if (m_ring[i]) m_buz = 1;
        for (int i = 0; i < N; i++) begin
            hit = m_en[i] && !(m_st != 0 && m_ptr == i) &&
                  m_tm[i][0] == c[0] && m_tm[i][1] == c[1] &&
                  m_tm[i][2] == c[2] && m_tm[i][3] == c[3];
            if (ack_btn) begin
                m_ring[i] = 1'b0; m_rc[i] = 0; m_snz[i] = 0;
            end else if (SNZ_ON && snooze_btn && m_ring[i]) begin
                m_ring[i] = 1'b0; m_rc[i] = 0; m_snz[i] = SNZ;
            end else if (mode_btn && m_st == 0 && int'(sel) == i) begin
                m_ring[i] = 1'b0; m_rc[i] = 0;
            end else if (min_tick) begin
                if (hit) begin
                    m_ring[i] = 1'b1; m_rc[i] = RNG;
                end else if (m_ring[i]) begin
                    m_rc[i]--;
                    if (m_rc[i] == 0) m_ring[i] = 1'b0;
                end
                if (m_snz[i] > 0) begin
                    m_snz[i]--;
                    if (m_snz[i] == 0) begin m_ring[i] = 1'b1; m_rc[i] = RNG; end
                end
            end
        end
        p = m_ptr;
        if (mode_btn) begin
            if (m_st == 0) m_ptr = int'(sel);
            m_st = (m_st + 1) % 6;
        end else if (set_btn) begin
            case (m_st)
                1: m_tm[p][0] = (m_tm[p][0] + 1) % 10;
                2: m_tm[p][1] = (m_tm[p][1] + 1) % 6;
                3: m_tm[p][2] = (m_tm[p][2] + 1) % ((m_tm[p][3] == 2) ? 4 : 10);
                4: begin
                    m_tm[p][3] = (m_tm[p][3] + 1) % 3;
                    if (m_tm[p][3] == 2 && m_tm[p][2] > 3) m_tm[p][2] = 3;
                end
                5: m_en[p] = !m_en[p];
                default: ;
            endcase
        end
    endtask

    task automatic compare_all();
        logic [N-1:0] e_en, e_ring;
        logic [15:0]  e_disp;
        int idx;
        for (int i = 0; i < N; i++) begin
            e_en[i] = m_en[i]; e_ring[i] = m_ring[i];
        end
        idx = (m_st == 0) ? int'(sel) : m_ptr;
        e_disp = {4'(m_tm[idx][3]), 4'(m_tm[idx][2]), 4'(m_tm[idx][1]), 4'(m_tm[idx][0])};
        chk("state", 32'(edit_state), 32'(m_st));
        chk("disp", 32'({disp_h1, disp_h0, disp_m1, disp_m0}), 32'(e_disp));
        chk("alarm_en", 32'(alarm_en), 32'(e_en));
        chk("ringing", 32'(ringing), 32'(e_ring));
        chk("buzzer", 32'(buzzer), 32'(m_buz));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
        mode_btn = 1'b0; set_btn = 1'b0; ack_btn = 1'b0; snooze_btn = 1'b0; min_tick = 1'b0;
    endtask

    task automatic press_mode();
        mode_btn = 1'b1; cyc();
    endtask

    task automatic press_set(input int n);
        repeat (n) begin set_btn = 1'b1; cyc(); end
    endtask

    task automatic tick_at(input logic [15:0] t);
        {cur_h1, cur_h0, cur_m1, cur_m0} = t;
        min_tick = 1'b1; cyc();
    endtask

    task automatic set_alarm(input int ch, input logic [15:0] t, input bit arm);
        sel = 2'(ch);
        press_mode(); press_set(int'(t[3:0]));
        press_mode(); press_set(int'(t[7:4]));
        press_mode(); press_set(int'(t[11:8]));
        press_mode(); press_set(int'(t[15:12]));
        press_mode(); if (arm) press_set(1);
        press_mode();
    endtask

    initial begin
        int k;
        model_reset();
        #12;
        compare_all();
        chk("reset_buzzer", 32'(buzzer), 32'd0);
        @(posedge clk); #1; rst = 1'b0;

        // Alarm 0 at 07:30: ring, buzzer one cycle later, auto-clear after 3 ticks
        set_alarm(0, 16'h0730, 1'b1);
        chk("a0_disp", 32'({disp_h1, disp_h0, disp_m1, disp_m0}), 32'h0730);
        chk("a0_armed", 32'(alarm_en), 32'b0001);
        tick_at(16'h0730);
        chk("a0_ring", 32'(ringing), 32'b0001);
        chk("a0_buz_lag", 32'(buzzer), 32'd0);
        cyc();
        chk("a0_buz", 32'(buzzer), 32'd1);
        tick_at(16'h0731); tick_at(16'h0732);
        chk("a0_still", 32'(ringing), 32'b0001);
        tick_at(16'h0733);
        chk("a0_auto_clr", 32'(ringing), 32'b0000);
        cyc();

        // Hour-digit clamp and wrap on channel 3
        sel = 2'd3;
        press_mode(); press_mode(); press_mode(); press_set(9); press_mode();
        press_set(1);
        chk("h1_to1", 32'({disp_h1, disp_h0, disp_m1, disp_m0}), 32'h1900);
        press_set(1);
        chk("h1_clamp", 32'({disp_h1, disp_h0, disp_m1, disp_m0}), 32'h2300);
        press_set(1);
        chk("h1_wrap", 32'({disp_h1, disp_h0, disp_m1, disp_m0}), 32'h0300);
        press_mode(); press_mode();

        // mode+set together, then channels 1 and 2 at 12:00
        sel = 2'd1;
        press_mode();
        mode_btn = 1'b1; set_btn = 1'b1; cyc();
        chk("mode_prio_st", 32'(edit_state), 32'd2);
        chk("mode_prio_m0", 32'(disp_m0), 32'd0);
        sel = 2'd3;
        press_mode(); press_set(2); press_mode(); press_set(1);
        press_mode(); press_set(1); press_mode();
        set_alarm(2, 16'h1200, 1'b1);
        chk("en_012", 32'(alarm_en), 32'b0111);
        tick_at(16'h1200);
        chk("dual_ring", 32'(ringing), 32'b0110);
        cyc();
        ack_btn = 1'b1; cyc();
        chk("ack_ring", 32'(ringing), 32'b0000);
        chk("ack_buz1", 32'(buzzer), 32'd1);
        cyc();
        chk("ack_buz2", 32'(buzzer), 32'd0);

        // Snooze behaviour
        tick_at(16'h0730);
        snooze_btn = 1'b1; cyc();
`ifdef SNOOZE_EN
        chk("snz_clr", 32'(ringing), 32'b0000);
        repeat (4) tick_at(16'h0731);
        chk("snz_wait", 32'(ringing), 32'b0000);
        tick_at(16'h0731);
        chk("snz_rering", 32'(ringing), 32'b0001);
        ack_btn = 1'b1; snooze_btn = 1'b1; cyc();
        chk("ack_snz", 32'(ringing), 32'b0000);
        repeat (6) tick_at(16'h0731);
        chk("no_pending", 32'(ringing), 32'b0000);
`else
        chk("snz_ignored", 32'(ringing), 32'b0001);
        ack_btn = 1'b1; cyc();
        chk("ack_after_snz", 32'(ringing), 32'b0000);
`endif

        // Entering edit of a ringing channel silences it
        tick_at(16'h0730);
        sel = 2'd0; press_mode();
        chk("edit_clr", 32'(ringing), 32'b0000);
        repeat (5) press_mode();

        // Reset mid-edit discards everything immediately
        sel = 2'd1;
        press_mode(); press_set(4); press_mode(); press_mode();
        chk("pre_rst_st", 32'(edit_state), 32'd3);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_state", 32'(edit_state), 32'd0);
        chk("rst_disp", 32'({disp_h1, disp_h0, disp_m1, disp_m0}), 32'h0000);
        chk("rst_en", 32'(alarm_en), 32'b0000);
        @(posedge clk); #1; rst = 1'b0;
        compare_all();

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            mode_btn   = ($urandom_range(0, 7) == 0);
            set_btn    = ($urandom_range(0, 1) == 0);
            ack_btn    = ($urandom_range(0, 29) == 0);
            snooze_btn = ($urandom_range(0, 14) == 0);
            min_tick   = ($urandom_range(0, 2) == 0);
            sel        = 2'($urandom_range(0, N - 1));
            if ($urandom_range(0, 1) == 0) begin
                k = $urandom_range(0, N - 1);
                cur_h1 = 4'(m_tm[k][3]); cur_h0 = 4'(m_tm[k][2]);
                cur_m1 = 4'(m_tm[k][1]); cur_m0 = 4'(m_tm[k][0]);
            end else begin
                cur_h1 = 4'($urandom_range(0, 2));
                cur_h0 = 4'((cur_h1 == 4'd2) ? $urandom_range(0, 3) : $urandom_range(0, 9));
                cur_m1 = 4'($urandom_range(0, 5));
                cur_m0 = 4'($urandom_range(0, 9));
            end
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_alarm_unit.md
MULTI_ALARM_UNIT -- requirements
Module: multi_alarm_unit

Interface
REQ-001 SHALL have parameter NUM_ALARMS, default 4: number of independent alarm channels, range 1-8.
REQ-002 SHALL have parameter SNOOZE_MIN, default 5: snooze delay in minutes, range 1-15.
REQ-003 SHALL have parameter RING_MIN, default 3: minutes a ringing channel stays active before auto-clear, range 1-15.
REQ-004 SHALL have port clk, input, 1: clock.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port min_tick, input, 1: one-cycle pulse per minute from the timekeeper.
REQ-007 SHALL have ports cur_h1, cur_h0, cur_m1, cur_m0, input, 4 each: current time in BCD, 24-hour.
REQ-008 SHALL have ports mode_btn, set_btn, ack_btn and snooze_btn, input, 1 each: debounced single-cycle pulses.
REQ-009 SHALL have port sel, input, $clog2(NUM_ALARMS) (minimum 1): channel to display or edit.
REQ-010 SHALL have ports disp_h1, disp_h0, disp_m1, disp_m0, output, 4 each: stored time of the displayed channel.
REQ-011 SHALL have port edit_state, output, 3: current FSM state encoding.
REQ-012 SHALL have ports alarm_en and ringing, output, NUM_ALARMS each: per-channel armed and ringing flags.
REQ-013 SHALL have port buzzer, output, 1: OR of ringing, registered.

Function
REQ-014 SHALL implement edit FSM states IDLE(0), SET_M0(1), SET_M1(2), SET_H0(3), SET_H1(4), ARM(5).
REQ-015 SHALL advance the FSM one state per mode_btn: IDLE->SET_M0->SET_M1->SET_H0->SET_H1->ARM->IDLE.
REQ-016 SHALL latch sel into the edit pointer on IDLE->SET_M0; sel changes are ignored until the FSM returns to IDLE.
REQ-017 SHALL increment the field selected by set_btn, once per pulse, in each SET_* state.
REQ-018 SHALL wrap m0 9->0, m1 5->0, h0 9->0 (3->0 when h1==2), and h1 2->0.
REQ-019 SHALL clamp h0 to 3 in the same cycle that h1 becomes 2 with h0>3.
REQ-020 SHALL toggle alarm_en of the edited channel on set_btn in ARM.
REQ-021 SHALL give mode_btn priority when mode_btn and set_btn arrive in the same cycle; set_btn is ignored.
REQ-022 SHALL drive disp_* from channel sel in IDLE and from the edited channel in all other states.
REQ-023 SHALL set ringing[i] on the cycle after min_tick when alarm_en[i]=1, the stored time equals cur_*, and channel i is not being edited.
REQ-024 SHALL clear ringing[i] after RING_MIN min_ticks, counted from assertion.
REQ-025 SHALL clear all ringing flags and pending snoozes on ack_btn, one cycle later.
REQ-026 SHALL give ack_btn priority over snooze_btn, and both priority over a same-cycle match.
REQ-027 SHALL clear ringing of a channel on entry to SET_M0 for that channel.
REQ-028 SHALL assert buzzer exactly one cycle after any ringing bit is set, and deassert it one cycle after all ringing bits clear.

Reset
REQ-029 SHALL, on rst, asynchronously clear: FSM to IDLE, all stored times to 00:00, alarm_en, ringing, buzzer, snooze and ring counters, and the edit pointer to 0.
REQ-030 SHALL discard a partial edit when rst is asserted mid-edit; no stored digit is retained.

Configuration
REQ-031 SHALL, with SNOOZE_EN defined, on snooze_btn clear ringing channels and load their snooze counters with SNOOZE_MIN.
REQ-032 SHALL decrement snooze counters on min_tick and re-assert ringing (with a fresh RING_MIN window) when a counter reaches 0.
REQ-033 SHALL, without SNOOZE_EN, ignore snooze_btn and synthesise no snooze counters.

Structure
REQ-034 SHALL place the state enum, a 4-bit BCD digit typedef, digit limit constants (9,5,9,2,3) and the state encodings in package multi_alarm_pkg.
REQ-035 SHALL instantiate sub-module alarm_channel NUM_ALARMS times via generate; each instance holds the stored time, enable flag, comparator, ring counter and snooze counter.

Verification
REQ-036 SHALL cover: set alarm 0 to 07:30 and arm it; cur=07:30 with min_tick -> ringing[0]=1 next cycle, buzzer=1 one cycle later; 3 further min_ticks -> ringing[0]=0.
REQ-037 SHALL cover: h1=1, h0=9; set in SET_H1 -> h1=2 and h0=3; set in SET_H1 again -> h1=0.
REQ-038 SHALL cover: alarms 1 and 2 both armed at 12:00; tick at 12:00 -> ringing=4'b0110; ack_btn -> ringing=0 and buzzer=0 two cycles later.
REQ-039 SHALL cover, with SNOOZE_EN: ring alarm 0, snooze_btn -> ringing=0; 5 min_ticks -> ringing[0]=1; ack_btn and snooze_btn same cycle -> cleared with no snooze pending.
REQ-040 SHALL cover: rst asserted in SET_H0 with m0=4 -> edit_state=0, disp=00:00, alarm_en=0 immediately.
REQ-041 SHALL cover: mode_btn and set_btn in the same cycle in SET_M0 -> state SET_M1, m0 unchanged.
